// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ALU control/execute unit:
// gout codes, aluop and funct encodings, decode bundle and FSM states.
package alu_ctrl_pkg;

   localparam logic [2:0] GOUT_AND = 3'b000;
   localparam logic [2:0] GOUT_OR  = 3'b001;
   localparam logic [2:0] GOUT_ADD = 3'b010;
   localparam logic [2:0] GOUT_NOR = 3'b100;
   localparam logic [2:0] GOUT_SLL = 3'b101;
   localparam logic [2:0] GOUT_SUB = 3'b110;
   localparam logic [2:0] GOUT_SLT = 3'b111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_NORI  = 2'b11;

   localparam logic [5:0] FUNCT_ADD   = 6'b100000;
   localparam logic [5:0] FUNCT_SUB   = 6'b100010;
   localparam logic [5:0] FUNCT_AND   = 6'b100100;
   localparam logic [5:0] FUNCT_OR    = 6'b100101;
   localparam logic [5:0] FUNCT_SLT   = 6'b101010;
   localparam logic [5:0] FUNCT_SLLV  = 6'b000100;
   localparam logic [5:0] FUNCT_BALRZ = 6'b010110;

   typedef struct packed {
      logic [2:0] gout;
      logic       balrz;
      logic       sllv;
      logic       err;
   } dec_t;

   localparam dec_t DEC_RESET = '{gout: GOUT_ADD, balrz: 1'b0, sllv: 1'b0, err: 1'b0};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Handshake and operand/result bundle between the register-read stage,
// the ALU control/execute unit and write-back.
interface alu_exec_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       aluop;
   logic [5:0]       funct;
   logic             bltz;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic [2:0]       gout;
   logic             balrz_o;
   logic             sllv_o;
   logic             err_o;

   modport master (
      output in_valid, aluop, funct, bltz, a, b, out_ready,
      input  in_ready, out_valid, result, zero, gout, balrz_o, sllv_o, err_o
   );

   modport slave (
      input  in_valid, aluop, funct, bltz, a, b, out_ready,
      output in_ready, out_valid, result, zero, gout, balrz_o, sllv_o, err_o
   );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational aluop/funct decode into the 3-bit ALU control code and op flags.
// Shared with the single-cycle datapath, so it carries no state.
module alu_ctrl_decode
   import alu_ctrl_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output dec_t       dec
);

   always_comb begin
      dec = DEC_RESET;
      case (aluop)
         ALUOP_ADD:  dec.gout = GOUT_ADD;
         ALUOP_SUB:  dec.gout = GOUT_SUB;
         ALUOP_NORI: dec.gout = GOUT_NOR;
         ALUOP_RTYPE: begin
            case (funct)
               FUNCT_ADD:   dec.gout = GOUT_ADD;
               FUNCT_SUB:   dec.gout = GOUT_SUB;
               FUNCT_AND:   dec.gout = GOUT_AND;
               FUNCT_OR:    dec.gout = GOUT_OR;
               FUNCT_SLT:   dec.gout = GOUT_SLT;
               FUNCT_SLLV: begin
                  dec.gout = GOUT_SLL;
                  dec.sllv = 1'b1;
               end
               FUNCT_BALRZ: begin
                  dec.gout  = GOUT_ADD;
                  dec.balrz = 1'b1;
               end
               default: begin
                  dec.gout = GOUT_ADD;
                  dec.err  = 1'b1;
               end
            endcase
         end
         default: dec.gout = GOUT_ADD;
      endcase
   end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle ALU control/execute unit: single-cycle ops finish in one cycle,
// sllv shifts one bit per cycle. Valid/ready on both sides.
//
// state    | meaning
// ST_IDLE  | in_ready high, waiting for an op
// ST_SHIFT | sllv in progress, one bit per cycle
// ST_DONE  | result held, out_valid high until out_ready
module alu_exec_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input logic            clk,
   input logic            rst_n,
   alu_exec_ctrl_if.slave bus
);

   state_e               state_q, state_d;
   dec_t                 dec_q, dec_d, dec_in;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 zero_q, zero_d;
   logic [WIDTH-1:0]     sreg_q, sreg_d;
   logic [SHAMT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]     alu_res;
   logic [SHAMT_W-1:0]   shamt;
   logic                 slt_bit;

   alu_ctrl_decode u_decode (
      .aluop (bus.aluop),
      .funct (bus.funct),
      .dec   (dec_in)
   );

   assign shamt   = bus.a[SHAMT_W-1:0];
   assign slt_bit = $signed(bus.a) < $signed(bus.b);

   always_comb begin
      alu_res = bus.a + bus.b;
      case (dec_in.gout)
         GOUT_AND: alu_res = bus.a & bus.b;
         GOUT_OR:  alu_res = bus.a | bus.b;
         GOUT_ADD: alu_res = dec_in.balrz ? bus.a : (bus.a + bus.b);
         GOUT_NOR: alu_res = ~(bus.a | bus.b);
         GOUT_SUB: alu_res = bus.a - bus.b;
         GOUT_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
         GOUT_SLL: alu_res = bus.b;
         default:  alu_res = bus.a + bus.b;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      dec_d    = dec_q;
      result_d = result_q;
      zero_d   = zero_q;
      sreg_d   = sreg_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               dec_d = dec_in;
               if (dec_in.sllv && (shamt != '0)) begin
                  sreg_d  = bus.b;
                  cnt_d   = shamt;
                  state_d = ST_SHIFT;
               end else begin
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
                  state_d  = ST_DONE;
               end
            end
         end
         ST_SHIFT: begin
            sreg_d = sreg_q << 1;
            cnt_d  = cnt_q - 1'b1;
            // the last shift goes straight into result, so sllv takes shamt cycles here
            if (cnt_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
               result_d = sreg_q << 1;
               zero_d   = ((sreg_q << 1) == '0);
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         dec_q    <= DEC_RESET;
         result_q <= '0;
         zero_q   <= 1'b0;
         sreg_q   <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         dec_q    <= dec_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         sreg_q   <= sreg_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.gout      = dec_q.gout;
   assign bus.balrz_o   = dec_q.balrz;
   assign bus.sllv_o    = dec_q.sllv;
   assign bus.err_o     = dec_q.err;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: directed ops from the test plan, a reset abort,
// then random ops checked against a behavioural model.
module tb_alu_exec_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   alu_exec_ctrl_if #(.WIDTH(32)) bus ();

   alu_exec_ctrl #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [31:0] res;
      logic [2:0]  gout;
      logic        balrz;
      logic        sllv;
      logic        err;
      int          lat;
   } exp_t;

   function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn,
                                  input logic [31:0] av, input logic [31:0] bv);
      exp_t e;
      int   sh;
      e.res = av + bv; e.gout = 3'b010; e.balrz = 0; e.sllv = 0; e.err = 0; e.lat = 1;
      if (op == 2'b01) begin
         e.res = av - bv; e.gout = 3'b110;
      end else if (op == 2'b11) begin
         e.res = ~(av | bv); e.gout = 3'b100;
      end else if (op == 2'b10) begin
         case (fn)
            6'b100000: ;
            6'b100010: begin e.res = av - bv; e.gout = 3'b110; end
            6'b100100: begin e.res = av & bv; e.gout = 3'b000; end
            6'b100101: begin e.res = av | bv; e.gout = 3'b001; end
            6'b101010: begin
               e.res = (int'(av) < int'(bv)) ? 32'd1 : 32'd0;
               e.gout = 3'b111;
            end
            6'b000100: begin
               sh = int'(av % 32);
               e.res = bv << sh; e.gout = 3'b101; e.sllv = 1; e.lat = 1 + sh;
            end
            6'b010110: begin e.res = av; e.balrz = 1; end
            default: e.err = 1;
         endcase
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] av, input logic [31:0] bv, input int hold);
      exp_t        e;
      int          guard;
      int          lat;
      logic        busy_ready;
      logic [31:0] held;
      e = model(op, fn, av, bv);
      guard = 0;
      @(negedge clk);
      while (!bus.in_ready && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
      bus.aluop = op; bus.funct = fn; bus.a = av; bus.b = bv;
      bus.bltz = 1'($urandom); bus.out_ready = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 1;
      busy_ready = 1'b0;
      while (!bus.out_valid && lat < 200) begin
         busy_ready = busy_ready | bus.in_ready;
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", 32'(lat), 32'(e.lat));
      chk("in_ready_busy", 32'(busy_ready | bus.in_ready), 32'd0);
      chk("result", bus.result, e.res);
      chk("zero", 32'(bus.zero), 32'(e.res == 32'd0));
      chk("gout", 32'(bus.gout), 32'(e.gout));
      chk("balrz_o", 32'(bus.balrz_o), 32'(e.balrz));
      chk("sllv_o", 32'(bus.sllv_o), 32'(e.sllv));
      chk("err_o", 32'(bus.err_o), 32'(e.err));
      held = bus.result;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         bus.a = $urandom; bus.b = $urandom; bus.aluop = 2'($urandom); bus.in_valid = 1'b1;
         @(posedge clk);
         #1;
         chk("hold_result", bus.result, held);
         chk("hold_valid", 32'(bus.out_valid), 32'd1);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("handoff_valid", 32'(bus.out_valid), 32'd0);
      chk("handoff_ready", 32'(bus.in_ready), 32'd1);
      bus.out_ready = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_result"}, bus.result, 32'd0);
      chk({tag, "_zero"}, 32'(bus.zero), 32'd0);
      chk({tag, "_gout"}, 32'(bus.gout), 32'd2);
      chk({tag, "_flags"}, {29'd0, bus.balrz_o, bus.sllv_o, bus.err_o}, 32'd0);
   endtask

   logic [5:0] fn_tab [8];
   logic       seen_valid;

   initial begin
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.aluop = 2'b00; bus.funct = 6'd0;
      bus.bltz = 1'b0; bus.a = '0; bus.b = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;

      run_op(2'b10, 6'b100000, 32'd5, 32'd7, 0);
      run_op(2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 0);
      run_op(2'b10, 6'b101010, 32'd1, 32'hFFFFFFFF, 0);
      run_op(2'b10, 6'b000100, 32'd31, 32'd1, 0);
      run_op(2'b10, 6'b000100, 32'd64, 32'h1234, 1);
      run_op(2'b11, 6'b000000, 32'h0F0F0000, 32'h0000F0F0, 5);
      run_op(2'b10, 6'b010110, 32'd0, 32'd9, 0);
      run_op(2'b10, 6'b111111, 32'd3, 32'd4, 0);
      run_op(2'b01, 6'b000000, 32'd4, 32'd4, 0);

      // abort a long shift with reset
      @(negedge clk);
      bus.aluop = 2'b10; bus.funct = 6'b000100; bus.a = 32'd20; bus.b = 32'd3;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("abort");
      seen_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (25) begin
         @(negedge clk);
         seen_valid = seen_valid | bus.out_valid;
      end
      chk("abort_no_valid", 32'(seen_valid), 32'd0);
      run_op(2'b10, 6'b100000, 32'd100, 32'd23, 0);

      fn_tab[0] = 6'b100000; fn_tab[1] = 6'b100010; fn_tab[2] = 6'b100100;
      fn_tab[3] = 6'b100101; fn_tab[4] = 6'b101010; fn_tab[5] = 6'b000100;
      fn_tab[6] = 6'b010110; fn_tab[7] = 6'($urandom);
      for (int i = 0; i < 30; i++) begin
         logic [5:0]  fn;
         logic [31:0] av;
         fn = fn_tab[$urandom_range(0, 7)];
         av = $urandom;
         if ($urandom_range(0, 3) == 0) av = 32'd0;
         run_op(2'($urandom_range(0, 3)), fn, av, $urandom, int'($urandom_range(0, 2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Parametrised, multi-cycle ALU control and execute unit for the MIPS datapath. It decodes `aluop` and `funct` into the 3-bit ALU control code and executes single-cycle ops (add, sub, and, or, slt, nori). It also executes the variable shift `sllv` iteratively, one bit per cycle. It sits between the main control/register-read stage and write-back, and talks to both through valid/ready handshakes.

## Interface
Parameters:
- `WIDTH`, 32, datapath width; a power of two, at least 8.
- `SHAMT_W`, `$clog2(WIDTH)`, shift-amount width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  unit can accept an operation; high only in IDLE.
- `aluop`  in  2  main-control ALU op.
- `funct`  in  6  R-type function field.
- `bltz`  in  1  branch-less-than-zero qualifier.
- `a`  in  WIDTH  operand A (rs).
- `b`  in  WIDTH  operand B (rt or extended immediate).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  `result == 0`, registered with `result`.
- `gout`  out  3  ALU control code of the last accepted op.
- `balrz_o`  out  1  last accepted op was balrz.
- `sllv_o`  out  1  last accepted op was sllv.
- `err_o`  out  1  last accepted R-type funct was unsupported.

## Operation
Decode (gout codes):
- `aluop`=00 -> add (010).
- `aluop`=01 -> sub (110), for beq/bne/bltz; `bltz` does not alter the code.
- `aluop`=11 -> nori (100): `~(a|b)`.
- `aluop`=10 -> R-type, by `funct`:
  - 100000 -> add (010)
  - 100010 -> sub (110)
  - 100100 -> and (000)
  - 100101 -> or (001)
  - 101010 -> slt (111)
  - 000100 -> sllv (101)
  - 010110 -> balrz: add (010) with result = `a`, so `zero` reflects rs == 0.
  - Any other funct -> add (010) with `err_o`=1.

Arithmetic:
- add/sub are modulo 2^WIDTH.
- slt is a signed compare; result = {(WIDTH-1) zeros, a<b}.
- sllv result = `b << a[SHAMT_W-1:0]`; upper bits of `a` are ignored.

FSM (IDLE, SHIFT, DONE):
- IDLE: `in_ready`=1. On `in_valid`, latch the decode outputs (`gout`, `balrz_o`, `sllv_o`, `err_o`). Then:
  - Non-shift op: load `result`/`zero`, go to DONE.
  - sllv with shamt=0: load `result`=`b`, go to DONE.
  - sllv with shamt>0: load the shift register with `b` and the counter with shamt, go to SHIFT.
- SHIFT: each cycle, shift register <<= 1 and counter -= 1. When the counter reaches 1, the next edge writes the final value to `result` and moves to DONE.
- DONE: `out_valid`=1; `result`, `zero` and flags are held stable. On `out_ready`, go to IDLE.

Boundary rules:
- `in_valid` is ignored outside IDLE; the producer holds its inputs until accepted.
- `out_ready` is ignored outside DONE.
- shamt = WIDTH-1 is the longest op.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `zero`=0, `gout`=010, `balrz_o`=`sllv_o`=`err_o`=0.
- Latency, from the accept edge to `out_valid` high:
  - Single-cycle op or sllv with shamt=0: 1 cycle.
  - sllv: 1+shamt cycles; worst case WIDTH cycles.
- Result handoff: the result transfers on the edge where `out_valid`&&`out_ready`. `in_ready` rises on the next cycle.
- Throughput: at most one op per 2 cycles; there is no accept in DONE.
- `rst_n` assertion mid-SHIFT or in DONE aborts the op immediately. No `out_valid` is produced, and outputs return to their reset values asynchronously.

## Structure
- Package `alu_ctrl_pkg` holds:
  - gout code constants (AND, OR, ADD, NOR, SLL, SUB, SLT);
  - aluop encodings;
  - funct constants;
  - the FSM state enum.
- Sub-module `alu_ctrl_decode`: purely combinational `aluop`/`funct` -> {`gout`, balrz, sllv, err}. It is instantiated once and is reusable by the single-cycle datapath.
- The FSM, shift counter, and result/flag registers live in `alu_exec_ctrl`.

## Test plan
- Reset, then `aluop`=10, `funct`=100000, a=5, b=7 -> one cycle later: `out_valid`=1, `result`=12, `gout`=010, `zero`=0.
- `aluop`=10, `funct`=101010, a=0xFFFFFFFF, b=1 -> `result`=1 (signed -1<1), `gout`=111. Then repeat with a=1, b=0xFFFFFFFF -> `result`=0, `zero`=1.
- sllv with a=31, b=1 -> `in_ready` low for 32 cycles, `out_valid` 32 cycles after accept, `result`=0x80000000, `sllv_o`=1, `gout`=101.
- `aluop`=11, a=0x0F0F0000, b=0x0000F0F0 -> `result`=0xF0F00F0F. Hold `out_ready`=0 for 5 cycles -> `result` stays stable and `in_valid` is ignored. Then raise `out_ready` -> IDLE.
- balrz (`funct`=010110) with a=0 -> `zero`=1, `balrz_o`=1. Unsupported `funct` 111111 -> `err_o`=1, `gout`=010.
- Start sllv with a=20 and drop `rst_n` on cycle 7 -> outputs reset immediately and no `out_valid` appears. After release, an add op completes normally.
